// File: rtl/multi_cycle_pkg.sv
// Shared encodings for the multi-cycle controller: state codes, RISC-V opcodes,
// ALU operation codes and ALU operand selects.
package multi_cycle_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StExecR    = 4'd2,
    StExecI    = 4'd3,
    StMemAddr  = 4'd4,
    StMemRead  = 4'd5,
    StMemWb    = 4'd6,
    StMemWrite = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StLui      = 4'd10,
    StIllegal  = 4'd11
  } state_e;

  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;

  localparam logic [2:0] AluFunct = 3'b000;
  localparam logic [2:0] AluSub   = 3'b001;
  localparam logic [2:0] AluPassB = 3'b010;
  localparam logic [2:0] AluAdd   = 3'b011;

  localparam logic [1:0] SrcAPc   = 2'b00;
  localparam logic [1:0] SrcARs1  = 2'b01;
  localparam logic [1:0] SrcAZero = 2'b10;
  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBFour = 2'b01;
  localparam logic [1:0] SrcBImm  = 2'b10;

endpackage

// File: rtl/mcc_output_decode.sv
// Control output decode for the multi-cycle controller. Moore outputs from the
// state code, plus the handshake- and Zero-qualified enables.
module mcc_output_decode
  import multi_cycle_pkg::*;
(
  input  logic [3:0] state,
  input  logic       Zero_i,
  input  logic       Mem_Ready_i,
  output logic       PC_Write_o,
  output logic       IR_Write_o,
  output logic       I_or_D_o,
  output logic       Mem_Read_o,
  output logic       Mem_Write_o,
  output logic       Mem_to_Reg_o,
  output logic       Reg_Write_o,
  output logic       PC_Src_o,
  output logic [1:0] ALU_Src_A_o,
  output logic [1:0] ALU_Src_B_o,
  output logic [2:0] ALU_Op_o,
  output logic       Instr_Done_o,
  output logic       Illegal_o
);

  always_comb begin
    PC_Write_o   = 1'b0;
    IR_Write_o   = 1'b0;
    I_or_D_o     = 1'b0;
    Mem_Read_o   = 1'b0;
    Mem_Write_o  = 1'b0;
    Mem_to_Reg_o = 1'b0;
    Reg_Write_o  = 1'b0;
    PC_Src_o     = 1'b0;
    ALU_Src_A_o  = SrcAPc;
    ALU_Src_B_o  = SrcBRs2;
    ALU_Op_o     = AluFunct;
    Instr_Done_o = 1'b0;
    Illegal_o    = 1'b0;
    case (state)
      StFetch: begin
        Mem_Read_o  = 1'b1;
        ALU_Src_B_o = SrcBFour;
        ALU_Op_o    = AluAdd;
        // IR load and PC+4 commit only when the instruction word arrives
        IR_Write_o  = Mem_Ready_i;
        PC_Write_o  = Mem_Ready_i;
      end
      StDecode: begin
        ALU_Src_B_o = SrcBImm;
        ALU_Op_o    = AluAdd;
      end
      StExecR: begin
        ALU_Src_A_o = SrcARs1;
      end
      StExecI: begin
        ALU_Src_A_o = SrcARs1;
        ALU_Src_B_o = SrcBImm;
      end
      StMemAddr: begin
        ALU_Src_A_o = SrcARs1;
        ALU_Src_B_o = SrcBImm;
        ALU_Op_o    = AluAdd;
      end
      StMemRead: begin
        I_or_D_o   = 1'b1;
        Mem_Read_o = 1'b1;
      end
      StMemWb: begin
        Reg_Write_o  = 1'b1;
        Mem_to_Reg_o = 1'b1;
        Instr_Done_o = 1'b1;
      end
      StMemWrite: begin
        I_or_D_o     = 1'b1;
        Mem_Write_o  = 1'b1;
        Instr_Done_o = Mem_Ready_i;
      end
      StAluWb: begin
        Reg_Write_o  = 1'b1;
        Instr_Done_o = 1'b1;
      end
      StBranch: begin
        ALU_Src_A_o  = SrcARs1;
        ALU_Op_o     = AluSub;
        PC_Src_o     = 1'b1;
        PC_Write_o   = Zero_i;
        Instr_Done_o = 1'b1;
      end
      StLui: begin
        ALU_Src_A_o = SrcAZero;
        ALU_Src_B_o = SrcBImm;
        ALU_Op_o    = AluPassB;
      end
      StIllegal: begin
        Illegal_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle RISC-V control FSM: state register, latched opcode and next-state
// logic; output decoding lives in mcc_output_decode.
module multi_cycle_control
  import multi_cycle_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] OP_i,
  input  logic       Zero_i,
  input  logic       Mem_Ready_i,
  output logic       PC_Write_o,
  output logic       IR_Write_o,
  output logic       I_or_D_o,
  output logic       Mem_Read_o,
  output logic       Mem_Write_o,
  output logic       Mem_to_Reg_o,
  output logic       Reg_Write_o,
  output logic       PC_Src_o,
  output logic [1:0] ALU_Src_A_o,
  output logic [1:0] ALU_Src_B_o,
  output logic [2:0] ALU_Op_o,
  output logic       Instr_Done_o,
  output logic       Illegal_o,
  output logic [3:0] State_o
);

  state_e     state_q, state_d;
  logic [6:0] op_q, op_d;
  logic [3:0] dec_state;
  logic       dec_pc_write, dec_ir_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      StFetch: begin
        if (Mem_Ready_i) state_d = StDecode;
      end
      StDecode: begin
        op_d = OP_i;
        case (OP_i)
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpLoad, OpStore: state_d = StMemAddr;
          OpBranch:        state_d = StBranch;
          OpLui:           state_d = StLui;
          default:         state_d = StIllegal;
        endcase
      end
      StExecR, StExecI, StLui: state_d = StAluWb;
      StMemAddr: state_d = (op_q == OpStore) ? StMemWrite : StMemRead;
      StMemRead: begin
        if (Mem_Ready_i) state_d = StMemWb;
      end
      StMemWrite: begin
        if (Mem_Ready_i) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // While reset is held the datapath sees FETCH controls with its enables off,
  // even if the register still holds a mid-instruction state.
  assign dec_state = reset ? StFetch : state_q;

  mcc_output_decode u_output_decode (
    .state        (dec_state),
    .Zero_i       (Zero_i),
    .Mem_Ready_i  (Mem_Ready_i),
    .PC_Write_o   (dec_pc_write),
    .IR_Write_o   (dec_ir_write),
    .I_or_D_o     (I_or_D_o),
    .Mem_Read_o   (Mem_Read_o),
    .Mem_Write_o  (Mem_Write_o),
    .Mem_to_Reg_o (Mem_to_Reg_o),
    .Reg_Write_o  (Reg_Write_o),
    .PC_Src_o     (PC_Src_o),
    .ALU_Src_A_o  (ALU_Src_A_o),
    .ALU_Src_B_o  (ALU_Src_B_o),
    .ALU_Op_o     (ALU_Op_o),
    .Instr_Done_o (Instr_Done_o),
    .Illegal_o    (Illegal_o)
  );

  assign PC_Write_o = dec_pc_write & ~reset;
  assign IR_Write_o = dec_ir_write & ~reset;
  assign State_o    = state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scenario bench for multi_cycle_control: per-cycle stimulus rows, expected
// control words pushed to a scoreboard at drive time and compared after settling.
module tb_multi_cycle_control;

  logic       clk;
  logic       reset;
  logic [6:0] OP_i;
  logic       Zero_i;
  logic       Mem_Ready_i;
  logic       PC_Write_o, IR_Write_o, I_or_D_o, Mem_Read_o, Mem_Write_o;
  logic       Mem_to_Reg_o, Reg_Write_o, PC_Src_o;
  logic [1:0] ALU_Src_A_o, ALU_Src_B_o;
  logic [2:0] ALU_Op_o;
  logic       Instr_Done_o, Illegal_o;
  logic [3:0] State_o;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, iord, mrd, mwr, m2r, rgw, pcs;
    logic [1:0] a, b;
    logic [2:0] op;
    logic       done, ill;
  } ctl_t;

  typedef struct packed {
    logic       rst;
    logic [6:0] op;
    logic       z, r;
    logic [3:0] st;
  } row_t;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011, BR = 7'b1100011, LU = 7'b0110111;
  localparam logic [6:0] XX = 7'b1111111;

  row_t stim_q[$];
  ctl_t sb_q[$];
  int   passed = 0;
  int   total  = 0;

  multi_cycle_control dut (
    .clk          (clk),
    .reset        (reset),
    .OP_i         (OP_i),
    .Zero_i       (Zero_i),
    .Mem_Ready_i  (Mem_Ready_i),
    .PC_Write_o   (PC_Write_o),
    .IR_Write_o   (IR_Write_o),
    .I_or_D_o     (I_or_D_o),
    .Mem_Read_o   (Mem_Read_o),
    .Mem_Write_o  (Mem_Write_o),
    .Mem_to_Reg_o (Mem_to_Reg_o),
    .Reg_Write_o  (Reg_Write_o),
    .PC_Src_o     (PC_Src_o),
    .ALU_Src_A_o  (ALU_Src_A_o),
    .ALU_Src_B_o  (ALU_Src_B_o),
    .ALU_Op_o     (ALU_Op_o),
    .Instr_Done_o (Instr_Done_o),
    .Illegal_o    (Illegal_o),
    .State_o      (State_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference control word per state, written from the control table.
  function automatic ctl_t exp_ctl(input logic [3:0] st, input logic z, input logic r,
                                   input logic rst);
    ctl_t e;
    e = '0;
    e.st = st;
    case (rst ? 4'd0 : st)
      4'd0:  begin e.mrd = 1; e.b = 2'b01; e.op = 3'b011; e.pcw = r & ~rst; e.irw = r & ~rst; end
      4'd1:  begin e.b = 2'b10; e.op = 3'b011; end
      4'd2:  begin e.a = 2'b01; end
      4'd3:  begin e.a = 2'b01; e.b = 2'b10; end
      4'd4:  begin e.a = 2'b01; e.b = 2'b10; e.op = 3'b011; end
      4'd5:  begin e.iord = 1; e.mrd = 1; end
      4'd6:  begin e.rgw = 1; e.m2r = 1; e.done = 1; end
      4'd7:  begin e.iord = 1; e.mwr = 1; e.done = r; end
      4'd8:  begin e.rgw = 1; e.done = 1; end
      4'd9:  begin e.a = 2'b01; e.op = 3'b001; e.pcs = 1; e.pcw = z; e.done = 1; end
      4'd10: begin e.a = 2'b10; e.b = 2'b10; e.op = 3'b010; end
      4'd11: begin e.ill = 1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic ctl_t sample();
    return {State_o, PC_Write_o, IR_Write_o, I_or_D_o, Mem_Read_o, Mem_Write_o, Mem_to_Reg_o,
            Reg_Write_o, PC_Src_o, ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, Instr_Done_o, Illegal_o};
  endfunction

  task automatic add(input logic rst, input logic [6:0] op, input logic z, input logic r,
                     input logic [3:0] st);
    stim_q.push_back({rst, op, z, r, st});
  endtask

  task automatic drive(input row_t rw);
    @(negedge clk);
    reset       = rw.rst;
    OP_i        = rw.op;
    Zero_i      = rw.z;
    Mem_Ready_i = rw.r;
    sb_q.push_back(exp_ctl(rw.st, rw.z, rw.r, rw.rst));
  endtask

  task automatic test_reset();
    row_t rw;
    ctl_t got, exp;
    int   k = 0;
    add(1, XX, 0, 1, 0); add(1, LD, 1, 1, 0);
    while (stim_q.size() > 0) begin
      rw = stim_q.pop_front(); drive(rw); #1;
      got = sample(); exp = sb_q.pop_front(); total++;
      if (got !== exp) $display("FAIL reset[%0d] got %h (state %0d) expected %h (state %0d)",
                                k, got, got.st, exp, exp.st);
      else passed++;
      k++;
    end
  endtask

  task automatic test_r_type();
    row_t rw;
    ctl_t got, exp;
    int   k = 0;
    add(0, XX, 0, 1, 0); add(0, R, 0, 0, 1); add(0, XX, 0, 0, 2); add(0, XX, 0, 1, 8);
    add(0, XX, 0, 0, 0);
    while (stim_q.size() > 0) begin
      rw = stim_q.pop_front(); drive(rw); #1;
      got = sample(); exp = sb_q.pop_front(); total++;
      if (got !== exp) $display("FAIL r_type[%0d] got %h (state %0d) expected %h (state %0d)",
                                k, got, got.st, exp, exp.st);
      else passed++;
      k++;
    end
  endtask

  task automatic test_load_wait();
    row_t rw;
    ctl_t got, exp;
    int   k = 0;
    add(0, XX, 0, 1, 0); add(0, LD, 0, 0, 1); add(0, XX, 0, 1, 4); add(0, XX, 0, 0, 5);
    add(0, XX, 0, 0, 5); add(0, XX, 0, 1, 5); add(0, XX, 0, 0, 6); add(0, XX, 0, 0, 0);
    while (stim_q.size() > 0) begin
      rw = stim_q.pop_front(); drive(rw); #1;
      got = sample(); exp = sb_q.pop_front(); total++;
      if (got !== exp) $display("FAIL load[%0d] got %h (state %0d) expected %h (state %0d)",
                                k, got, got.st, exp, exp.st);
      else passed++;
      k++;
    end
  endtask

  task automatic test_store();
    row_t rw;
    ctl_t got, exp;
    int   k = 0;
    add(0, XX, 0, 1, 0); add(0, SW, 0, 0, 1); add(0, XX, 0, 1, 4); add(0, XX, 0, 0, 7);
    add(0, XX, 0, 1, 7); add(0, XX, 0, 0, 0);
    while (stim_q.size() > 0) begin
      rw = stim_q.pop_front(); drive(rw); #1;
      got = sample(); exp = sb_q.pop_front(); total++;
      if (got !== exp) $display("FAIL store[%0d] got %h (state %0d) expected %h (state %0d)",
                                k, got, got.st, exp, exp.st);
      else passed++;
      k++;
    end
  endtask

  task automatic test_branch();
    row_t rw;
    ctl_t got, exp;
    int   k = 0;
    add(0, XX, 1, 1, 0); add(0, BR, 1, 0, 1); add(0, XX, 1, 0, 9);
    add(0, XX, 0, 1, 0); add(0, BR, 0, 0, 1); add(0, XX, 0, 1, 9);
    add(0, XX, 1, 0, 0);
    while (stim_q.size() > 0) begin
      rw = stim_q.pop_front(); drive(rw); #1;
      got = sample(); exp = sb_q.pop_front(); total++;
      if (got !== exp) $display("FAIL branch[%0d] got %h (state %0d) expected %h (state %0d)",
                                k, got, got.st, exp, exp.st);
      else passed++;
      k++;
    end
  endtask

  task automatic test_illegal();
    row_t rw;
    ctl_t got, exp;
    int   k = 0;
    add(0, XX, 0, 1, 0); add(0, XX, 0, 0, 1); add(0, SW, 0, 1, 11); add(0, XX, 0, 0, 0);
    while (stim_q.size() > 0) begin
      rw = stim_q.pop_front(); drive(rw); #1;
      got = sample(); exp = sb_q.pop_front(); total++;
      if (got !== exp) $display("FAIL illegal[%0d] got %h (state %0d) expected %h (state %0d)",
                                k, got, got.st, exp, exp.st);
      else passed++;
      k++;
    end
  endtask

  task automatic test_back_to_back();
    row_t rw;
    ctl_t got, exp;
    int   k = 0;
    add(0, XX, 0, 1, 0); add(0, I, 0, 0, 1); add(0, XX, 0, 0, 3); add(0, XX, 0, 0, 8);
    add(0, XX, 0, 1, 0); add(0, LU, 0, 1, 1); add(0, XX, 0, 1, 10); add(0, XX, 0, 1, 8);
    add(0, XX, 0, 0, 0);
    while (stim_q.size() > 0) begin
      rw = stim_q.pop_front(); drive(rw); #1;
      got = sample(); exp = sb_q.pop_front(); total++;
      if (got !== exp) $display("FAIL b2b[%0d] got %h (state %0d) expected %h (state %0d)",
                                k, got, got.st, exp, exp.st);
      else passed++;
      k++;
    end
  endtask

  task automatic test_fetch_wait();
    row_t rw;
    ctl_t got, exp;
    int   k = 0;
    add(0, XX, 0, 0, 0); add(0, XX, 0, 0, 0); add(0, XX, 0, 0, 0); add(0, XX, 0, 1, 0);
    add(0, R, 0, 0, 1); add(0, XX, 0, 0, 2); add(0, XX, 0, 0, 8); add(0, XX, 0, 0, 0);
    while (stim_q.size() > 0) begin
      rw = stim_q.pop_front(); drive(rw); #1;
      got = sample(); exp = sb_q.pop_front(); total++;
      if (got !== exp) $display("FAIL fetch_wait[%0d] got %h (state %0d) expected %h (state %0d)",
                                k, got, got.st, exp, exp.st);
      else passed++;
      k++;
    end
  endtask

  task automatic test_reset_mid_write();
    row_t rw;
    ctl_t got, exp;
    int   k = 0;
    add(0, XX, 0, 1, 0); add(0, SW, 0, 0, 1); add(0, XX, 0, 0, 4); add(0, XX, 0, 0, 7);
    add(1, XX, 0, 1, 7); add(0, XX, 0, 0, 0); add(0, XX, 0, 0, 0);
    while (stim_q.size() > 0) begin
      rw = stim_q.pop_front(); drive(rw); #1;
      got = sample(); exp = sb_q.pop_front(); total++;
      if (got !== exp) $display("FAIL reset_write[%0d] got %h (state %0d) expected %h (state %0d)",
                                k, got, got.st, exp, exp.st);
      else passed++;
      k++;
    end
  endtask

  initial begin
    reset       = 1'b1;
    OP_i        = XX;
    Zero_i      = 1'b0;
    Mem_Ready_i = 1'b1;
    test_reset();
    test_r_type();
    test_load_wait();
    test_store();
    test_branch();
    test_illegal();
    test_back_to_back();
    test_fetch_wait();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
